doppler_bank_scheduler: RTL and testbench

DOPPLER_BANK_SCHEDULER -- requirements
Module: doppler_bank_scheduler

---
 rtl/doppler_buf_pkg.sv | 29 ++
 rtl/doppler_out_skid.sv | 55 +++++
 rtl/doppler_bank_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_doppler_bank_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/doppler_buf_pkg.sv
// Shared defaults and type definitions for the Doppler corner-turn buffer.
package doppler_buf_pkg;

  localparam int unsigned NUM_CHIRPS_DEF = 256;
  localparam int unsigned NUM_BINS_DEF   = 128;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ADDR_W_DEF     = 15;

  // Lifecycle of one ping-pong bank.
  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // Write-side frame tracking: waiting for a frame, storing it, or discarding it.
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DROP
  } wr_mode_t;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/doppler_out_skid.sv
// Two-entry output FIFO feeding the Doppler sample stream.
module doppler_out_skid #(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;
  logic [1:0]   kept;

  // Pop shifts tail into head; a push lands in the first slot left empty after the pop.
  always_comb begin
    pop    = (cnt_q != 2'd0) && ready;
    kept   = cnt_q - 2'(pop);
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = tail_q;
    end
    if (push && (kept == 2'd0)) begin
      head_d = push_data;
    end else if (push && (kept == 2'd1)) begin
      tail_d = push_data;
    end
    cnt_d = (push && (kept != 2'd2)) ? kept + 2'd1 : kept;
  end

  // FIFO storage and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign data  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/doppler_bank_scheduler.sv
// Ping-pong corner-turn buffer: range-FFT rows in, Doppler columns out.
module doppler_bank_scheduler
  import doppler_buf_pkg::*;
#(
  parameter int unsigned NUM_CHIRPS = NUM_CHIRPS_DEF,
  parameter int unsigned NUM_BINS   = NUM_BINS_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_wea,
  output logic              bram_ena,
  input  logic [DATA_W-1:0] bram_douta,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [DATA_W-1:0] bram_dinb,
  output logic              bram_web,
  output logic              bram_enb,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [15:0]       frames_done,
  output logic [15:0]       overrun_count
);

  localparam int unsigned ROW_W = (NUM_CHIRPS > 1) ? $clog2(NUM_CHIRPS) : 1;
  localparam int unsigned COL_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int unsigned SK_W  = DATA_W + 2;
  localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'(NUM_CHIRPS * NUM_BINS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(NUM_CHIRPS - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_BINS - 1);

  bank_state_t bank_state_q [2];
  bank_state_t bank_state_d [2];

  wr_mode_t          wr_mode_q, wr_mode_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              last_filled_q, last_filled_d;
  logic              have_filled_q, have_filled_d;
  logic [15:0]       overrun_q, overrun_d;

  logic              rd_bank_q, rd_bank_d;
  logic [ROW_W-1:0]  rd_row_q, rd_row_d;
  logic [COL_W-1:0]  rd_col_q, rd_col_d;
  logic              rd_issued_q, rd_issued_d;
  logic              inflight_q, inflight_d;
  logic              inflight_bank_q, inflight_bank_d;
  logic              inflight_last_q, inflight_last_d;
  logic              inflight_end_q, inflight_end_d;
  logic [15:0]       frames_q, frames_d;

  logic              wr_go, wr_sel, claim_go, claim_bank, fill_done;
  logic              pref_bank, alt_bank;
  logic              start_drain, drain_sel, drain_done, any_draining;
  logic              rd_go, pop;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] rd_addr;

  logic              sk_valid;
  logic [SK_W-1:0]   sk_data;
  logic [SK_W-1:0]   sk_push_data;
  logic [1:0]        sk_count;

  logic [1:0][ADDR_W-1:0] port_addr;
  logic [1:0][DATA_W-1:0] port_din;
  logic [1:0]             port_we;
  logic [1:0]             port_en;

  // Write side: claim a bank (or start dropping) on a frame's first sample, then count samples.
  always_comb begin
    wr_mode_d     = wr_mode_q;
    wr_cnt_d      = wr_cnt_q;
    wr_bank_d     = wr_bank_q;
    last_filled_d = last_filled_q;
    have_filled_d = have_filled_q;
    overrun_d     = overrun_q;
    wr_go         = 1'b0;
    wr_sel        = wr_bank_q;
    claim_go      = 1'b0;
    claim_bank    = 1'b0;
    fill_done     = 1'b0;
    pref_bank     = have_filled_q ? ~last_filled_q : 1'b0;
    alt_bank      = ~pref_bank;
    if (s_valid) begin
      unique case (wr_mode_q)
        WR_IDLE: begin
          wr_cnt_d = ADDR_W'(1);
          if (bank_state_q[pref_bank] == BANK_FREE) begin
            claim_go   = 1'b1;
            claim_bank = pref_bank;
          end else if (bank_state_q[alt_bank] == BANK_FREE) begin
            claim_go   = 1'b1;
            claim_bank = alt_bank;
          end
          if (claim_go) begin
            wr_go         = 1'b1;
            wr_sel        = claim_bank;
            wr_bank_d     = claim_bank;
            last_filled_d = claim_bank;
            have_filled_d = 1'b1;
            wr_mode_d     = WR_FILL;
          end else begin
            overrun_d = sat_inc16(overrun_q);
            wr_mode_d = WR_DROP;
          end
        end
        WR_FILL: begin
          wr_go = 1'b1;
          if (wr_cnt_q == LAST_WR) begin
            wr_cnt_d  = '0;
            wr_mode_d = WR_IDLE;
            fill_done = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end
        WR_DROP: begin
          if (wr_cnt_q == LAST_WR) begin
            wr_cnt_d  = '0;
            wr_mode_d = WR_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          wr_mode_d = WR_IDLE;
          wr_cnt_d  = '0;
        end
      endcase
    end
  end

  // Read side: pick the oldest full bank, walk it column-major under FIFO credit, retire on last accept.
  always_comb begin
    rd_bank_d       = rd_bank_q;
    rd_row_d        = rd_row_q;
    rd_col_d        = rd_col_q;
    rd_issued_d     = rd_issued_q;
    inflight_d      = 1'b0;
    inflight_bank_d = rd_bank_q;
    inflight_last_d = 1'b0;
    inflight_end_d  = 1'b0;
    frames_d        = frames_q;
    start_drain     = 1'b0;
    drain_sel       = 1'b0;
    any_draining    = (bank_state_q[0] == BANK_DRAINING) || (bank_state_q[1] == BANK_DRAINING);
    if (!any_draining) begin
      if ((bank_state_q[0] == BANK_FULL) && (bank_state_q[1] == BANK_FULL)) begin
        start_drain = 1'b1;
        drain_sel   = ~last_filled_q;
      end else if (bank_state_q[0] == BANK_FULL) begin
        start_drain = 1'b1;
        drain_sel   = 1'b0;
      end else if (bank_state_q[1] == BANK_FULL) begin
        start_drain = 1'b1;
        drain_sel   = 1'b1;
      end
    end
    pop     = sk_valid && m_ready;
    occ     = 3'(sk_count) + 3'(inflight_q) - 3'(pop);
    rd_go   = (bank_state_q[rd_bank_q] == BANK_DRAINING) && !rd_issued_q && (occ < 3'd2);
    rd_addr = ADDR_W'(rd_row_q) * ADDR_W'(NUM_BINS) + ADDR_W'(rd_col_q);
    if (rd_go) begin
      inflight_d      = 1'b1;
      inflight_last_d = (rd_row_q == LAST_ROW);
      inflight_end_d  = (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);
      if (rd_row_q == LAST_ROW) begin
        rd_row_d = '0;
        if (rd_col_q == LAST_COL) begin
          rd_issued_d = 1'b1;
        end else begin
          rd_col_d = rd_col_q + COL_W'(1);
        end
      end else begin
        rd_row_d = rd_row_q + ROW_W'(1);
      end
    end
    if (start_drain) begin
      rd_bank_d   = drain_sel;
      rd_row_d    = '0;
      rd_col_d    = '0;
      rd_issued_d = 1'b0;
    end
    drain_done = pop && sk_data[SK_W-1];
    if (drain_done) begin
      frames_d = frames_q + 16'd1;
    end
  end

  // Bank lifecycle; each event targets a bank in a distinct state, so they never collide.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      bank_state_d[b] = bank_state_q[b];
    end
    if (claim_go)    bank_state_d[claim_bank] = BANK_FILLING;
    if (fill_done)   bank_state_d[wr_bank_q]  = BANK_FULL;
    if (drain_done)  bank_state_d[rd_bank_q]  = BANK_FREE;
    if (start_drain) bank_state_d[drain_sel]  = BANK_DRAINING;
  end

  // Route the write or the read onto each bank port.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      port_addr[b] = '0;
      port_din[b]  = '0;
      port_we[b]   = 1'b0;
      port_en[b]   = 1'b0;
      if (wr_go && (wr_sel == 1'(b))) begin
        port_addr[b] = wr_cnt_q;
        port_din[b]  = s_data;
        port_we[b]   = 1'b1;
        port_en[b]   = 1'b1;
      end else if (rd_go && (rd_bank_q == 1'(b))) begin
        port_addr[b] = rd_addr;
        port_en[b]   = 1'b1;
      end
    end
  end

  // All state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        bank_state_q[b] <= BANK_FREE;
      end
      wr_mode_q       <= WR_IDLE;
      wr_cnt_q        <= '0;
      wr_bank_q       <= 1'b0;
      last_filled_q   <= 1'b0;
      have_filled_q   <= 1'b0;
      overrun_q       <= '0;
      rd_bank_q       <= 1'b0;
      rd_row_q        <= '0;
      rd_col_q        <= '0;
      rd_issued_q     <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_end_q  <= 1'b0;
      frames_q        <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        bank_state_q[b] <= bank_state_d[b];
      end
      wr_mode_q       <= wr_mode_d;
      wr_cnt_q        <= wr_cnt_d;
      wr_bank_q       <= wr_bank_d;
      last_filled_q   <= last_filled_d;
      have_filled_q   <= have_filled_d;
      overrun_q       <= overrun_d;
      rd_bank_q       <= rd_bank_d;
      rd_row_q        <= rd_row_d;
      rd_col_q        <= rd_col_d;
      rd_issued_q     <= rd_issued_d;
      inflight_q      <= inflight_d;
      inflight_bank_q <= inflight_bank_d;
      inflight_last_q <= inflight_last_d;
      inflight_end_q  <= inflight_end_d;
      frames_q        <= frames_d;
    end
  end

  assign sk_push_data = {inflight_end_q, inflight_last_q, inflight_bank_q ? bram_doutb : bram_douta};

  doppler_out_skid #(
    .W (SK_W)
  ) u_out_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (sk_push_data),
    .ready     (m_ready),
    .valid     (sk_valid),
    .data      (sk_data),
    .count     (sk_count)
  );

  // Drive outputs, forced to zero while reset is held.
  always_comb begin
    bram_addra    = port_addr[0];
    bram_dina     = port_din[0];
    bram_wea      = port_we[0];
    bram_ena      = port_en[0];
    bram_addrb    = port_addr[1];
    bram_dinb     = port_din[1];
    bram_web      = port_we[1];
    bram_enb      = port_en[1];
    m_data        = sk_data[DATA_W-1:0];
    m_valid       = sk_valid;
    m_last        = sk_data[SK_W-2];
    wr_bank       = wr_bank_q;
    rd_bank       = rd_bank_q;
    frames_done   = frames_q;
    overrun_count = overrun_q;
    if (rst) begin
      bram_addra    = '0;
      bram_dina     = '0;
      bram_wea      = 1'b0;
      bram_ena      = 1'b0;
      bram_addrb    = '0;
      bram_dinb     = '0;
      bram_web      = 1'b0;
      bram_enb      = 1'b0;
      m_data        = '0;
      m_valid       = 1'b0;
      m_last        = 1'b0;
      wr_bank       = 1'b0;
      rd_bank       = 1'b0;
      frames_done   = '0;
      overrun_count = '0;
    end
  end

endmodule

// File: tb/tb_doppler_bank_scheduler.sv
// Directed bench for doppler_bank_scheduler using a reduced 4x8 frame.
module tb_doppler_bank_scheduler;

  localparam int NC = 4;
  localparam int NB = 8;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int FR = NC * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [DW-1:0] bram_dina, bram_dinb, bram_douta, bram_doutb;
  logic          bram_wea, bram_ena, bram_web, bram_enb;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          wr_bank, rd_bank;
  logic [15:0]   frames_done, overrun_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  doppler_bank_scheduler #(
    .NUM_CHIRPS (NC),
    .NUM_BINS   (NB),
    .DATA_W     (DW),
    .ADDR_W     (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .bram_addra    (bram_addra),
    .bram_dina     (bram_dina),
    .bram_wea      (bram_wea),
    .bram_ena      (bram_ena),
    .bram_douta    (bram_douta),
    .bram_addrb    (bram_addrb),
    .bram_dinb     (bram_dinb),
    .bram_web      (bram_web),
    .bram_enb      (bram_enb),
    .bram_doutb    (bram_doutb),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .frames_done   (frames_done),
    .overrun_count (overrun_count)
  );

  // Bank memories with one-cycle read latency.
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_wea) mem_a[bram_addra] <= bram_dina;
      bram_douta <= mem_a[bram_addra];
    end
    if (bram_enb) begin
      if (bram_web) mem_b[bram_addrb] <= bram_dinb;
      bram_doutb <= mem_b[bram_addrb];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepted outputs are logged; stalled outputs must hold their value.
  logic [DW:0] outq[$];
  logic        stall_q = 1'b0;
  logic [DW:0] stall_word = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("hold", {m_valid, m_last, m_data}, {1'b1, stall_word});
      if (m_valid && m_ready) outq.push_back({m_last, m_data});
      stall_q    = m_valid && !m_ready;
      stall_word = {m_last, m_data};
    end
  end

  function automatic logic [DW:0] exp_out(input int base, input int k);
    int col;
    int row;
    col = k / NC;
    row = k % NC;
    return {(row == NC - 1), DW'(base + row * NB + col)};
  endfunction

  task automatic check_queue(input int nfr, input int base0);
    check("out_count", 64'(outq.size()), 64'(nfr * FR));
    for (int i = 0; i < nfr * FR && i < outq.size(); i++)
      check($sformatf("out%0d", i), 64'(outq[i]), 64'(exp_out(base0 + (i / FR) * FR, i % FR)));
  endtask

  // One clock cycle of stimulus; returns at the falling edge for sampling.
  task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst     = r;
    s_valid = v;
    s_data  = d;
    m_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    logic v;
    logic [DW-1:0] d;
    int n;

    // Reset with s_valid high: nothing may be written or shown.
    repeat (3) drive(1'b1, 1'b1, 32'hDEAD, 1'b1);
    check("rst_ports", {bram_ena, bram_wea, bram_enb, bram_web}, 64'd0);
    check("rst_stream", {m_valid, m_last, m_data}, 64'd0);
    check("rst_status", {wr_bank, rd_bank, frames_done, overrun_count}, 64'd0);
    outq.delete();

    // Frames 0 and 1 back to back, frame 2 timed so A's last write meets B's last accept.
    for (int c = 0; c < 140; c++) begin
      v = (c < 64) || (c >= 70 && c < 102);
      d = (c < 64) ? DW'(c) : DW'(c - 6);
      drive(1'b0, v, d, 1'b1);
      if (c < 32)
        check("wr_a", {bram_ena, bram_wea, bram_addra, bram_dina}, {1'b1, 1'b1, AW'(c), DW'(c)});
      if (c >= 32 && c < 64)
        check("wr_b", {bram_enb, bram_web, bram_addrb, bram_dinb}, {1'b1, 1'b1, AW'(c - 32), DW'(c)});
      if (c >= 70 && c < 102)
        check("wr_a2", {bram_ena, bram_wea, bram_addra, bram_dina}, {1'b1, 1'b1, AW'(c - 70), DW'(c - 6)});
      if (c == 33) check("first_rd", {bram_ena, bram_wea, bram_addra}, {1'b1, 1'b0, AW'(0)});
      if (c == 34) check("lat_valid0", m_valid, 64'd0);
      if (c == 35) check("out_first", {m_valid, m_last, m_data}, {1'b1, 1'b0, 32'd0});
      if (c == 36) check("out_second", {m_valid, m_last, m_data}, {1'b1, 1'b0, 32'd8});
      if (c == 38) check("out_collast", {m_valid, m_last, m_data}, {1'b1, 1'b1, 32'd24});
      if (c == 40) check("wr_bank_b", wr_bank, 64'd1);
      if (c == 101) check("frames_pre", frames_done, 64'd1);
      if (c == 102) check("sim_events", {frames_done, bram_ena}, {16'd2, 1'b0});
      if (c == 103) check("drain_a2", {rd_bank, bram_ena, bram_wea, bram_addra}, {1'b0, 1'b1, 1'b0, AW'(0)});
    end
    check("frames3", frames_done, 64'd3);
    check("no_overrun", overrun_count, 64'd0);
    check_queue(3, 0);

    // Downstream stalled: two frames fill both banks, the third is dropped.
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    check("rst2_status", {frames_done, overrun_count, m_valid}, 64'd0);
    outq.delete();
    for (int c = 0; c < 96; c++) begin
      drive(1'b0, 1'b1, DW'(c), 1'b0);
      if (c >= 32 && c < 64)
        check("wr_b_stall", {bram_enb, bram_web, bram_addrb, bram_dinb}, {1'b1, 1'b1, AW'(c - 32), DW'(c)});
      if (c >= 64) check("drop_no_we", {bram_wea, bram_web}, 64'd0);
      if (c == 40 || c == 95) check("stall_out", {m_valid, m_data}, {1'b1, 32'd0});
      if (c == 65 || c == 95) check("overrun1", overrun_count, 64'd1);
    end

    // Random back-pressure while both banks drain.
    n = 0;
    while (frames_done != 16'd2 && n < 400) begin
      drive(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)));
      n++;
    end
    check("drain2_done", frames_done, 64'd2);
    repeat (4) drive(1'b0, 1'b0, '0, 1'b1);
    check("idle_after", m_valid, 64'd0);
    check("overrun_final", overrun_count, 64'd1);
    check_queue(2, 0);

    // Reset mid-frame while B drains; next frame restarts in bank A at address 0.
    drive(1'b1, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b1);
    for (int c = 0; c < 90; c++) begin
      v = (c < 64) || (c >= 70);
      d = (c < 64) ? DW'(c) : DW'(c - 6);
      drive(1'b0, v, d, 1'b1);
    end
    check("pre_rst_drain", {rd_bank, m_valid}, {1'b1, 1'b1});
    drive(1'b1, 1'b1, 32'd84, 1'b1);
    check("rst_mid_ports", {bram_ena, bram_wea, bram_enb, bram_web, m_valid}, 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("post_rst_ports", {bram_ena, bram_wea, bram_enb, bram_web}, 64'd0);
    check("post_rst_stream", {m_valid, m_last, m_data}, 64'd0);
    check("post_rst_status", {wr_bank, rd_bank, frames_done, overrun_count}, 64'd0);
    outq.delete();
    for (int c = 0; c < 32; c++) begin
      drive(1'b0, 1'b1, DW'(500 + c), 1'b1);
      check("wr_a_rst", {bram_ena, bram_wea, bram_addra, bram_dina}, {1'b1, 1'b1, AW'(c), DW'(500 + c)});
      check("no_b_rst", {bram_enb, bram_web}, 64'd0);
    end
    repeat (45) drive(1'b0, 1'b0, '0, 1'b1);
    check("frames_rst", frames_done, 64'd1);
    check_queue(1, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
